// File: rtl/if_id_skid_reg_if.sv
// IF/ID handshake bundle: fetch-side push channel, decode-side pop channel and flush.
// The master modport belongs to the surrounding pipeline; the slave modport belongs to the skid register.
interface if_id_skid_reg_if #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;

  modport master (
    output in_valid, in_instr, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_pc
  );

  modport slave (
    input  in_valid, in_instr, in_pc, flush, out_ready,
    output in_ready, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer, flush and full throughput.
// Optional `IFID_STALL_CNT_EN adds a saturating decode-stall counter output.
module if_id_skid_reg #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 32
) (
  input  logic                Clk,
  input  logic                Reset,
  if_id_skid_reg_if.slave     bus
`ifdef IFID_STALL_CNT_EN
  ,
  output logic [15:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

  state_e             r_state;
  logic               r_out_valid;
  logic               r_in_ready;
  logic [INSTR_W-1:0] r_main_instr;
  logic [PC_W-1:0]    r_main_pc;
  logic [INSTR_W-1:0] r_skid_instr;
  logic [PC_W-1:0]    r_skid_pc;

  logic w_push;
  logic w_pop;

  assign w_push = bus.in_valid & r_in_ready;
  assign w_pop  = r_out_valid & bus.out_ready;

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_instr = r_main_instr;
  assign bus.out_pc    = r_main_pc;

  // Handshake outputs are registered alongside the state so no input reaches them combinationally.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state      <= StEmpty;
      r_out_valid  <= 1'b0;
      r_in_ready   <= 1'b1;
      r_main_instr <= '0;
      r_main_pc    <= '0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
    end else if (bus.flush) begin
      r_state     <= StEmpty;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        StEmpty: begin
          if (w_push) begin
            r_main_instr <= bus.in_instr;
            r_main_pc    <= bus.in_pc;
            r_state      <= StOne;
            r_out_valid  <= 1'b1;
          end
        end
        StOne: begin
          if (w_push && !w_pop) begin
            r_skid_instr <= bus.in_instr;
            r_skid_pc    <= bus.in_pc;
            r_state      <= StTwo;
            r_in_ready   <= 1'b0;
          end else if (w_push && w_pop) begin
            r_main_instr <= bus.in_instr;
            r_main_pc    <= bus.in_pc;
          end else if (w_pop) begin
            r_state     <= StEmpty;
            r_out_valid <= 1'b0;
          end
        end
        StTwo: begin
          if (w_pop) begin
            r_main_instr <= r_skid_instr;
            r_main_pc    <= r_skid_pc;
            r_state      <= StOne;
            r_in_ready   <= 1'b1;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
        end
      endcase
    end
  end

`ifdef IFID_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_stall_cnt <= '0;
    end else if (bus.flush) begin
      r_stall_cnt <= '0;
    end else if (r_out_valid && !bus.out_ready && (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: reset, streaming, skid fill/drain, flush, stall hold, async reset.
module tb_if_id_skid_reg;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  if_id_skid_reg_if #(.INSTR_W(INSTR_W), .PC_W(PC_W)) bus ();

`ifdef IFID_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  if_id_skid_reg #(.INSTR_W(INSTR_W), .PC_W(PC_W)) u_dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .bus       (bus.slave)
`ifdef IFID_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and land 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_pc    = pc;
    bus.in_instr = 32'h0000_0020 + pc;
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    step();

    // Reset state
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_instr", bus.out_instr, 0);
    check("rst_out_pc",    bus.out_pc,    0);

    // Back-to-back stream, no bubbles
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i));
      step();
      check("strm_valid", bus.out_valid, 1);
      check("strm_pc",    bus.out_pc,    64'(4 * i));
      check("strm_instr", bus.out_instr, 64'(32'h20 + 4 * i));
      check("strm_ready", bus.in_ready,  1);
    end
    drive(1'b0, 0);
    step();
    check("strm_drain", bus.out_valid, 0);

    // Fill skid, then drain in order
    bus.out_ready = 1'b0;
    drive(1'b1, 0);
    step();
    drive(1'b1, 4);
    step();
    check("two_in_ready",  bus.in_ready,  0);
    check("two_out_valid", bus.out_valid, 1);
    check("two_out_pc",    bus.out_pc,    0);
    drive(1'b1, 8);
    step();
    check("two_hold_pc",   bus.out_pc,    0);
    check("two_hold_rdy",  bus.in_ready,  0);
    drive(1'b0, 0);
    bus.out_ready = 1'b1;
    step();
    check("pop1_pc",    bus.out_pc,    4);
    check("pop1_instr", bus.out_instr, 64'h24);
    check("pop1_ready", bus.in_ready,  1);
    step();
    check("pop2_valid", bus.out_valid, 0);

    // Flush in TWO with a concurrent input
    bus.out_ready = 1'b0;
    drive(1'b1, 0);
    step();
    drive(1'b1, 4);
    step();
    drive(1'b1, 8);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 0);
    check("fl2_out_valid", bus.out_valid, 0);
    check("fl2_in_ready",  bus.in_ready,  1);
    bus.out_ready = 1'b1;
    step();
    check("fl2_no_pc8", bus.out_valid, 0);

    // Flush in ONE with a push that would otherwise land
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h40);
    step();
    drive(1'b1, 32'h44);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    drive(1'b0, 0);
    check("fl1_out_valid", bus.out_valid, 0);
    check("fl1_in_ready",  bus.in_ready,  1);

    // Stall hold for 5 cycles
    drive(1'b1, 0);
    step();
    drive(1'b0, 0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_pc",    bus.out_pc,    0);
      check("stall_instr", bus.out_instr, 64'h20);
      check("stall_valid", bus.out_valid, 1);
    end
`ifdef IFID_STALL_CNT_EN
    check("stall_cnt", stall_cnt, 5);
`endif
    bus.out_ready = 1'b1;
    step();
    check("stall_drain", bus.out_valid, 0);

    // Asynchronous reset mid-stream in ONE
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h100);
    step();
    drive(1'b0, 0);
    check("ar_pre_pc", bus.out_pc, 64'h100);
    #1 rst_n = 1'b0;
    #1;
    check("ar_out_valid", bus.out_valid, 0);
    check("ar_in_ready",  bus.in_ready,  1);
    check("ar_out_pc",    bus.out_pc,    0);
    check("ar_out_instr", bus.out_instr, 0);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h200);
    step();
    drive(1'b0, 0);
    check("ar_restart_valid", bus.out_valid, 1);
    check("ar_restart_pc",    bus.out_pc,    64'h200);
    step();
    check("ar_restart_drain", bus.out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
